// File: rtl/matrix_multiplier_pkg.sv
// rtl/matrix_multiplier_pkg.sv - shared region codes, FSM states and control bit positions
package matrix_multiplier_pkg;

  localparam logic [1:0] REG_A    = 2'b00;
  localparam logic [1:0] REG_B    = 2'b01;
  localparam logic [1:0] REG_C    = 2'b10;
  localparam logic [1:0] REG_CTRL = 2'b11;

  localparam int CTRL_START_BIT = 0;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    STORE,
    DONE
  } state_t;

endpackage

// File: rtl/mm_mac_unit.sv
// rtl/mm_mac_unit.sv - signed multiply-accumulate with clear/enable
// MATRIX_MULTIPLIER_SATURATE_EN: clamp the result to the DW-bit signed range and flag it.
module mm_mac_unit #(
  parameter int DW = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic        [DW-1:0] result,
  output logic                 saturated
);

  logic signed [2*DW-1:0] product;
  logic signed [2*DW-1:0] acc;

  assign product = $signed({{DW{a[DW-1]}}, a}) * $signed({{DW{b[DW-1]}}, b});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + product;
    end
  end

`ifdef MATRIX_MULTIPLIER_SATURATE_EN
  // The value fits only when every bit above the result's sign bit copies it.
  logic fits;
  assign fits      = (&acc[2*DW-1:DW-1]) || ~(|acc[2*DW-1:DW-1]);
  assign saturated = ~fits;
  always_comb begin
    result = acc[DW-1:0];
    if (!fits) begin
      result = acc[2*DW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end
  end
`else
  logic unused_hi;
  assign unused_hi = ^acc[2*DW-1:DW];
  assign result    = acc[DW-1:0];
  assign saturated = 1'b0;
`endif

endmodule

// File: rtl/matrix_multiplier.sv
// rtl/matrix_multiplier.sv - memory-mapped NxN signed matrix multiplier, C = A x B
// Saturation (MATRIX_MULTIPLIER_SATURATE_EN) lives in mm_mac_unit; status bit2 follows it.
module matrix_multiplier
  import matrix_multiplier_pkg::*;
#(
  parameter int N  = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] memory_data_in,
  input  logic [11:0]   memory_address,
  input  logic          write_enable,
  output logic [DW-1:0] memory_data_out,
  output logic          result_ready
);

  localparam int NN = N * N;
  localparam int AW = $clog2(NN);
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST   = IW'(N - 1);
  localparam logic [10:0]   NN_LIM = 11'(NN);

  state_t state, state_next;
  logic [IW-1:0] i, j, k;
  logic [DW-1:0] a_mem [NN];
  logic [DW-1:0] b_mem [NN];
  logic [DW-1:0] c_mem [NN];

  logic [1:0]    region;
  logic [9:0]    offset;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          busy;
  logic          start_req;
  logic          mem_we;
  logic          mac_clear;
  logic          mac_en;
  logic          c_we;
  logic          ovf;
  logic          mac_saturated;
  logic [DW-1:0] mac_result;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] a_idx, b_idx, c_idx;

  assign region    = memory_address[11:10];
  assign offset    = memory_address[9:0];
  assign in_range  = {1'b0, offset} < NN_LIM;
  assign idx       = offset[AW-1:0];
  assign busy      = (state != IDLE);
  assign start_req = write_enable && (region == REG_CTRL) && memory_data_in[CTRL_START_BIT] && !busy;
  assign mem_we    = write_enable && !busy && in_range;

  assign a_idx = AW'(i) * AW'(N) + AW'(k);
  assign b_idx = AW'(k) * AW'(N) + AW'(j);
  assign c_idx = AW'(i) * AW'(N) + AW'(j);

  mm_mac_unit #(.DW(DW)) u_mac (
    .clk       (clk),
    .rst       (reset),
    .clear     (mac_clear),
    .enable    (mac_en),
    .a         (a_mem[a_idx]),
    .b         (b_mem[b_idx]),
    .result    (mac_result),
    .saturated (mac_saturated)
  );

  // Storage arrays keep their contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we && region == REG_A) a_mem[idx] <= memory_data_in;
    if (mem_we && region == REG_B) b_mem[idx] <= memory_data_in;
    if (c_we) c_mem[c_idx] <= mac_result;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_req) state_next = MAC;
      MAC:     if (k == LAST) state_next = STORE;
      STORE:   state_next = (i == LAST && j == LAST) ? DONE : MAC;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mac_clear = 1'b0;
    mac_en    = 1'b0;
    c_we      = 1'b0;
    case (state)
      IDLE:  mac_clear = start_req;
      MAC:   mac_en = 1'b1;
      STORE: begin
        mac_clear = 1'b1;
        c_we      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i            <= '0;
      j            <= '0;
      k            <= '0;
      result_ready <= 1'b0;
      ovf          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_req) begin
          i            <= '0;
          j            <= '0;
          k            <= '0;
          result_ready <= 1'b0;
          ovf          <= 1'b0;
        end
        MAC: k <= (k == LAST) ? '0 : k + 1'b1;
        STORE: begin
          if (mac_saturated) ovf <= 1'b1;
          if (j == LAST) begin
            j <= '0;
            i <= (i == LAST) ? '0 : i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        DONE: result_ready <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (region)
      REG_A:    if (in_range) rd_data = a_mem[idx];
      REG_B:    if (in_range) rd_data = b_mem[idx];
      REG_C:    if (in_range) rd_data = c_mem[idx];
      REG_CTRL: rd_data = DW'({ovf, result_ready, busy});
      default:  rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) memory_data_out <= '0;
    else       memory_data_out <= rd_data;
  end

endmodule

// File: tb/tb_matrix_multiplier.sv
// tb/tb_matrix_multiplier.sv - self-checking bench for matrix_multiplier (N=4)
module tb_matrix_multiplier;

  localparam int N   = 4;
  localparam int NN  = N * N;
  localparam int LAT = NN * (N + 1) + 1;
  localparam logic [11:0] A0   = 12'h000;
  localparam logic [11:0] B0   = 12'h400;
  localparam logic [11:0] C0   = 12'h800;
  localparam logic [11:0] CTRL = 12'hC00;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] memory_data_in = '0;
  logic [11:0] memory_address = CTRL;
  logic        write_enable = 1'b0;
  logic [31:0] memory_data_out;
  logic        result_ready;

  matrix_multiplier #(.N(N), .DW(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .memory_data_in  (memory_data_in),
    .memory_address  (memory_address),
    .write_enable    (write_enable),
    .memory_data_out (memory_data_out),
    .result_ready    (result_ready)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Behavioural model: whole-matrix product computed at completion time.
  int          ma [NN];
  int          mb [NN];
  int          mc [NN];
  int          run_left = 0;
  bit          m_ready = 1'b0;
  bit          m_ovf = 1'b0;
  bit          mc_valid = 1'b0;
  bit          chk_en = 1'b0;
  logic [31:0] chk_exp = '0;
  logic [1:0]  rg;
  int          off;
  bit          busy_m;
  longint      acc_m;
  int          edge_no = 0;

  always @(posedge clk) edge_no++;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      if (run_left > 0) mc_valid = 1'b0;
      run_left = 0;
      m_ready  = 1'b0;
      m_ovf    = 1'b0;
      chk_en   = 1'b1;
      chk_exp  = '0;
    end else begin
      rg      = memory_address[11:10];
      off     = int'(memory_address[9:0]);
      busy_m  = run_left > 0;
      chk_en  = 1'b1;
      chk_exp = '0;
      if (rg == 2'd3) begin
        chk_exp = {29'b0, m_ovf, m_ready, busy_m};
      end else if (off < NN) begin
        if (rg == 2'd0) chk_exp = ma[off];
        if (rg == 2'd1) chk_exp = mb[off];
        if (rg == 2'd2) begin
          chk_exp = mc[off];
          chk_en  = mc_valid && !busy_m;
        end
      end
      if (busy_m) begin
        run_left--;
        if (run_left == 0) begin
          for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
              acc_m = 0;
              for (int kk = 0; kk < N; kk++)
                acc_m += longint'(ma[r*N+kk]) * longint'(mb[kk*N+c]);
`ifdef MATRIX_MULTIPLIER_SATURATE_EN
              if (acc_m > SMAX) begin
                mc[r*N+c] = 32'h7FFFFFFF;
                m_ovf = 1'b1;
              end else if (acc_m < SMIN) begin
                mc[r*N+c] = 32'h80000000;
                m_ovf = 1'b1;
              end else begin
                mc[r*N+c] = int'(acc_m);
              end
`else
              mc[r*N+c] = int'(acc_m);
`endif
            end
          end
          m_ready  = 1'b1;
          mc_valid = 1'b1;
        end
      end else if (write_enable) begin
        if (rg == 2'd3 && memory_data_in[0]) begin
          run_left = LAT;
          m_ready  = 1'b0;
          m_ovf    = 1'b0;
        end else if (off < NN && rg == 2'd0) begin
          ma[off] = memory_data_in;
        end else if (off < NN && rg == 2'd1) begin
          mb[off] = memory_data_in;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("result_ready", {31'b0, result_ready}, {31'b0, m_ready});
    if (chk_en) check("read_data", memory_data_out, chk_exp);
  end

  // Directed stimulus; inputs change 1 time unit after the rising edge.
  int va [NN];
  int vb [NN];
  int s_edge = 0;
  int lat;

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    memory_address = a;
    memory_data_in = d;
    write_enable   = 1'b1;
    @(posedge clk); #1;
    write_enable   = 1'b0;
    memory_address = CTRL;
    memory_data_in = '0;
  endtask

  task automatic rd_lit(input logic [11:0] a, input logic [31:0] exp, input string name);
    memory_address = a;
    @(posedge clk); #1;
    check(name, memory_data_out, exp);
    memory_address = CTRL;
  endtask

  task automatic load();
    for (int n = 0; n < NN; n++) wr(A0 + 12'(n), va[n]);
    for (int n = 0; n < NN; n++) wr(B0 + 12'(n), vb[n]);
  endtask

  task automatic do_start();
    wr(CTRL, 32'd1);
    s_edge = edge_no;
  endtask

  task automatic wait_ready(input string name);
    int guard = 0;
    while (!result_ready && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    lat = edge_no - s_edge;
    check(name, lat, 32'd81);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    // Reset: 100 ns at a 20 ns period.
    repeat (5) @(posedge clk);
    #1;
    check("reset_data_out", memory_data_out, 32'h0);
    check("reset_ready", {31'b0, result_ready}, 32'h0);
    reset = 1'b0;
    rd_lit(CTRL, 32'h0, "status_after_reset");

    // Identity A, B[r][c] = r*4+c.
    for (int n = 0; n < NN; n++) begin
      va[n] = (n / N == n % N) ? 1 : 0;
      vb[n] = n;
    end
    load();
    do_start();
    wait_ready("latency_identity");
    for (int n = 0; n < NN; n++) rd_lit(C0 + 12'(n), 32'(n), "identity_c");
    rd_lit(CTRL, 32'h2, "status_done");
    rd_lit(A0 + 12'd5, 32'd1, "a_readback");
    rd_lit(B0 + 12'd7, 32'd7, "b_readback");
    wr(A0 + 12'd20, 32'd99);
    rd_lit(A0 + 12'd20, 32'h0, "a_out_of_range");
    rd_lit(C0 + 12'd16, 32'h0, "c_out_of_range");
    wr(C0, 32'd77);
    rd_lit(C0, 32'h0, "c_write_ignored");
    wr(A0 + 12'd5, 32'd1);
    check("ready_kept_after_ab_write", {31'b0, result_ready}, 32'h1);

    // Constant matrices.
    for (int n = 0; n < NN; n++) begin
      va[n] = 2;
      vb[n] = 3;
    end
    load();
    do_start();
    wait_ready("latency_constant");
    for (int n = 0; n < NN; n++) rd_lit(C0 + 12'(n), 32'h18, "constant_c");
    rd_lit(CTRL, 32'h2, "status_constant");

    // Negative operands.
    for (int n = 0; n < NN; n++) begin
      va[n] = -3;
      vb[n] = 5;
    end
    load();
    do_start();
    wait_ready("latency_negative");
    rd_lit(C0 + 12'd0, 32'hFFFFFFC4, "negative_c0");
    rd_lit(C0 + 12'd15, 32'hFFFFFFC4, "negative_c15");

    // Overflow of a single element.
    for (int n = 0; n < NN; n++) begin
      va[n] = 0;
      vb[n] = 0;
    end
    va[0] = 32'h7FFFFFFF;
    vb[0] = 2;
    load();
    do_start();
    wait_ready("latency_overflow");
`ifdef MATRIX_MULTIPLIER_SATURATE_EN
    rd_lit(C0, 32'h7FFFFFFF, "overflow_c0");
    rd_lit(CTRL, 32'h6, "status_overflow");
`else
    rd_lit(C0, 32'hFFFFFFFE, "overflow_c0");
    rd_lit(CTRL, 32'h2, "status_overflow");
`endif
    rd_lit(C0 + 12'd1, 32'h0, "overflow_c1");

    // Busy protection: writes and a second start during a run are dropped.
    for (int n = 0; n < NN; n++) begin
      va[n] = (n / N == n % N) ? 1 : 0;
      vb[n] = n;
    end
    load();
    do_start();
    repeat (9) @(posedge clk);
    #1;
    wr(A0, 32'd5);
    wr(CTRL, 32'd1);
    rd_lit(CTRL, 32'h1, "status_busy");
    wait_ready("latency_busy");
    rd_lit(A0, 32'd1, "a_protected");
    for (int n = 0; n < NN; n++) rd_lit(C0 + 12'(n), 32'(n), "busy_run_c");

    // Reset in the middle of a run, then a clean run.
    do_start();
    repeat (29) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready_mid_reset", {31'b0, result_ready}, 32'h0);
    check("data_out_mid_reset", memory_data_out, 32'h0);
    reset = 1'b0;
    rd_lit(CTRL, 32'h0, "status_after_mid_reset");
    for (int n = 0; n < NN; n++) vb[n] = 2 * n;
    for (int n = 0; n < NN; n++) wr(B0 + 12'(n), vb[n]);
    do_start();
    wait_ready("latency_after_reset");
    for (int n = 0; n < NN; n++) rd_lit(C0 + 12'(n), 32'(2 * n), "fresh_run_c");

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
